adder_rr_arbiter: RTL

Round-robin controller that shares one registered adder (1-cycle latency, BITWIDTH-bit operands, BITWIDTH+1-bit sum, enable/clear inputs) between NUM_REQ requesters. It accepts requests over per-requester valid/ready handshakes, sequences the adder through a grant/capture/response state machine, and returns each sum with the requester ID over a single valid/ready response channel. It sits between the requesting datapath lanes and the shared ADDER instance.

---
 rtl/adder_rr_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/adder_rr_arbiter.sv
// Shares one registered adder among NUM_REQ requesters in round-robin order; request->response latency 3 cycles, 4-cycle minimum per transaction.
// Backpressure: oRspValid/oRspId/oRspData hold until iRspReady, and no new grant is issued before that response is accepted.
module adder_rr_arbiter #(
    parameter int BITWIDTH = 32,
    parameter int NUM_REQ  = 4,
    parameter int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         iClk,
    input  logic                         iRstN,
    input  logic                         iEn,
    input  logic                         iClr,
    input  logic [NUM_REQ-1:0]           iReqValid,
    output logic [NUM_REQ-1:0]           oReqReady,
    input  logic [NUM_REQ*BITWIDTH-1:0]  iReqData0,
    input  logic [NUM_REQ*BITWIDTH-1:0]  iReqData1,
    output logic                         oAddEn,
    output logic                         oAddClr,
    output logic [BITWIDTH-1:0]          oAddData0,
    output logic [BITWIDTH-1:0]          oAddData1,
    input  logic [BITWIDTH:0]            iAddSum,
    output logic                         oRspValid,
    input  logic                         iRspReady,
    output logic [ID_W-1:0]              oRspId,
    output logic [BITWIDTH:0]            oRspData
);

    typedef enum logic [1:0] {IDLE, GRANT, CAPTURE, RESP} state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     winner_q, winner_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [BITWIDTH:0]   rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]     pick;
    logic                pick_vld;
    logic [ID_W:0]       cand;

    // First valid requester at or above ptr, wrapping around NUM_REQ.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!pick_vld && iReqValid[cand[ID_W-1:0]]) begin
                pick     = cand[ID_W-1:0];
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        winner_d   = winner_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        if (iClr) begin
            state_d    = IDLE;
            rsp_id_d   = '0;
            rsp_data_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (iEn && pick_vld) begin
                        winner_d = pick;
                        state_d  = GRANT;
                    end
                end
                GRANT: begin
                    ptr_d   = (winner_q == ID_W'(NUM_REQ-1)) ? '0 : winner_q + ID_W'(1);
                    state_d = CAPTURE;
                end
                CAPTURE: begin
                    // Adder output is valid exactly one cycle after the GRANT cycle.
                    rsp_data_d = iAddSum;
                    rsp_id_d   = winner_q;
                    state_d    = RESP;
                end
                RESP: begin
                    if (iRspReady) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            winner_q   <= '0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            winner_q   <= winner_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    always_comb begin
        oReqReady = '0;
        if (state_q == GRANT && !iClr) begin
            oReqReady[winner_q] = 1'b1;
        end
    end

    assign oAddEn    = (state_q == GRANT);
    assign oAddClr   = iClr;
    assign oAddData0 = (state_q == GRANT) ? iReqData0[int'(winner_q)*BITWIDTH +: BITWIDTH] : '0;
    assign oAddData1 = (state_q == GRANT) ? iReqData1[int'(winner_q)*BITWIDTH +: BITWIDTH] : '0;
    assign oRspValid = (state_q == RESP);
    assign oRspId    = rsp_id_q;
    assign oRspData  = rsp_data_q;

endmodule
